branch_sequencer: RTL and testbench

//  LC-3 control-flow sequencer: executes BR, JMP/RET and JSR/JSRR once the decoder hands it an IR.

---
 rtl/branch_sequencer.sv | 157 +++++++++++++++
 tb/tb_branch_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_sequencer.sv
// branch_sequencer: LC-3 control-flow sequencer for BR, JMP/RET and JSR/JSRR.
// Owns the PC, drives the BEN block handshake and the link-register write.
module branch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [2:0]  LINK_REG = 3'd7
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [15:0] ir,
    input  logic        pc_inc,
    output logic [2:0]  nzp_mask,
    output logic        ld_ben,
    input  logic        ben,
    output logic [2:0]  rf_rd_addr,
    input  logic [15:0] rf_rd_data,
    output logic        rf_wr_en,
    output logic [2:0]  rf_wr_addr,
    output logic [15:0] rf_wr_data,
    output logic [15:0] pc,
    output logic        busy,
    output logic        done,
    output logic        taken,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BR_LD,
        S_BR_EVAL,
        S_JMP,
        S_JSR_TGT,
        S_JSR_LINK,
        S_DONE
    } state_t;

    state_t      state, state_nx;
    // Opcode is consumed at issue, so only the operand field is kept.
    logic [11:0] ir_q, ir_nx;
    logic [15:0] pc_q, pc_nx;
    logic [15:0] tgt_q, tgt_nx;
    logic        taken_q, taken_nx;
    logic        illegal_q, illegal_nx;

    logic [15:0] sext9;
    logic [15:0] sext11;
    logic        is_br;
    logic        is_jmp;
    logic        is_jsr;

    assign sext9  = {{7{ir_q[8]}}, ir_q[8:0]};
    assign sext11 = {{5{ir_q[10]}}, ir_q[10:0]};

    assign is_br  = (ir[15:12] == 4'b0000);
    assign is_jmp = (ir[15:12] == 4'b1100);
    assign is_jsr = (ir[15:12] == 4'b0100);

    assign nzp_mask   = ir_q[11:9];
    assign rf_rd_addr = ir_q[8:6];
    assign rf_wr_addr = LINK_REG;
    assign rf_wr_data = pc_q;
    assign pc         = pc_q;

    // State, PC, latched IR, jump target and retire flags.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            tgt_q     <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_nx;
            pc_q      <= pc_nx;
            ir_q      <= ir_nx;
            tgt_q     <= tgt_nx;
            taken_q   <= taken_nx;
            illegal_q <= illegal_nx;
        end
    end

    // Next-state, datapath updates and strobes for each instruction class.
    always_comb begin
        state_nx   = state;
        pc_nx      = pc_q;
        ir_nx      = ir_q;
        tgt_nx     = tgt_q;
        taken_nx   = taken_q;
        illegal_nx = illegal_q;
        ld_ben     = 1'b0;
        rf_wr_en   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        taken      = 1'b0;
        illegal    = 1'b0;

        unique case (state)
            S_IDLE: begin
                busy       = 1'b0;
                taken_nx   = 1'b0;
                illegal_nx = 1'b0;
                if (start) begin
                    ir_nx = ir[11:0];
                    unique case (1'b1)
                        is_br:   state_nx = S_BR_LD;
                        is_jmp:  state_nx = S_JMP;
                        is_jsr:  state_nx = S_JSR_TGT;
                        default: begin
                            state_nx   = S_DONE;
                            illegal_nx = 1'b1;
                        end
                    endcase
                end else if (pc_inc) begin
                    pc_nx = pc_q + 16'd1;
                end
            end
            S_BR_LD: begin
                ld_ben   = 1'b1;
                state_nx = S_BR_EVAL;
            end
            S_BR_EVAL: begin
                if (ben) begin
                    pc_nx    = pc_q + sext9;
                    taken_nx = 1'b1;
                end
                state_nx = S_DONE;
            end
            S_JMP: begin
                pc_nx    = rf_rd_data;
                taken_nx = 1'b1;
                state_nx = S_DONE;
            end
            S_JSR_TGT: begin
                // Capture BaseR now so JSRR R7 uses R7 before the link write.
                tgt_nx   = ir_q[11] ? (pc_q + sext11) : rf_rd_data;
                state_nx = S_JSR_LINK;
            end
            S_JSR_LINK: begin
                rf_wr_en = 1'b1;
                pc_nx    = tgt_q;
                taken_nx = 1'b1;
                state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                taken    = taken_q;
                illegal  = illegal_q;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: directed checks of branch_sequencer.
// Behavioural register file; expected values are hand-computed.
module tb_branch_sequencer;

    logic        Clk;
    logic        Reset;
    logic        start;
    logic [15:0] ir;
    logic        pc_inc;
    logic [2:0]  nzp_mask;
    logic        ld_ben;
    logic        ben;
    logic [2:0]  rf_rd_addr;
    logic [15:0] rf_rd_data;
    logic        rf_wr_en;
    logic [2:0]  rf_wr_addr;
    logic [15:0] rf_wr_data;
    logic [15:0] pc;
    logic        busy;
    logic        done;
    logic        taken;
    logic        illegal;

    logic [15:0] rf [8];
    int          wr_count;
    int          passed;
    int          total;

    branch_sequencer dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .start      (start),
        .ir         (ir),
        .pc_inc     (pc_inc),
        .nzp_mask   (nzp_mask),
        .ld_ben     (ld_ben),
        .ben        (ben),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .pc         (pc),
        .busy       (busy),
        .done       (done),
        .taken      (taken),
        .illegal    (illegal)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Register file: combinational read, write on the clock edge.
    assign rf_rd_data = rf[rf_rd_addr];

    always @(posedge Clk) begin
        if (rf_wr_en) begin
            rf[rf_wr_addr] <= rf_wr_data;
            wr_count       <= wr_count + 1;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Present one instruction for a single cycle; afterwards we sit in cycle 1.
    task automatic issue(input logic [15:0] instr);
        ir    = instr;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    // Move PC to a known value through JMP R1.
    task automatic set_pc(input logic [15:0] v);
        rf[1] = v;
        issue(16'hC040);
        tick();
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        chk("reset_pc", pc, 16'h0000);
        chk("reset_busy", {15'd0, busy}, 16'd0);
        chk("reset_done", {15'd0, done}, 16'd0);
        chk("reset_strobes", {14'd0, ld_ben, rf_wr_en}, 16'd0);
        chk("reset_flags", {14'd0, taken, illegal}, 16'd0);
        chk("reset_nzp", {13'd0, nzp_mask}, 16'd0);
    endtask

    task automatic test_pc_inc();
        pc_inc = 1'b1;
        tick();
        tick();
        tick();
        pc_inc = 1'b0;
        chk("pc_inc_x3", pc, 16'h0003);
        pc_inc = 1'b1;
        issue(16'h1000);
        chk("start_wins_pc", pc, 16'h0003);
        chk("illegal_done", {15'd0, done}, 16'd1);
        chk("illegal_flag", {15'd0, illegal}, 16'd1);
        chk("illegal_taken", {15'd0, taken}, 16'd0);
        chk("pc_inc_in_done", pc, 16'h0003);
        tick();
        pc_inc = 1'b0;
        chk("illegal_idle", {14'd0, busy, done}, 16'd0);
        chk("pc_inc_in_done_ignored", pc, 16'h0003);
    endtask

    task automatic test_jmp();
        int w0;
        w0    = wr_count;
        rf[3] = 16'h4010;
        pc_inc = 1'b1;
        issue(16'hC0C0);
        ir    = 16'h1000;
        start = 1'b1;
        chk("jmp_c1_busy", {14'd0, busy, done}, 16'b10);
        chk("jmp_c1_pc", pc, 16'h0003);
        tick();
        start = 1'b0;
        pc_inc = 1'b0;
        chk("jmp_c2_done", {15'd0, done}, 16'd1);
        chk("jmp_taken", {14'd0, taken, illegal}, 16'b10);
        chk("jmp_pc", pc, 16'h4010);
        tick();
        chk("jmp_idle", {14'd0, busy, done}, 16'd0);
        chk("jmp_pc_hold", pc, 16'h4010);
        chk("jmp_no_wr", wr_count[15:0], w0[15:0]);
    endtask

    task automatic test_jsrr();
        int w0;
        w0    = wr_count;
        rf[7] = 16'h5000;
        issue(16'h41C0);
        chk("jsrr_c1_wr", {15'd0, rf_wr_en}, 16'd0);
        tick();
        chk("jsrr_c2_wr", {15'd0, rf_wr_en}, 16'd1);
        chk("jsrr_wr_addr", {13'd0, rf_wr_addr}, 16'd7);
        chk("jsrr_wr_data", rf_wr_data, 16'h4010);
        tick();
        chk("jsrr_c3_done", {14'd0, done, taken}, 16'b11);
        chk("jsrr_pc", pc, 16'h5000);
        chk("jsrr_r7", rf[7], 16'h4010);
        chk("jsrr_one_wr", wr_count[15:0], w0[15:0] + 16'd1);
        tick();
    endtask

    task automatic test_br(input logic [15:0] instr, input logic b,
                           input logic [2:0] mask,
                           input logic [15:0] exp_pc, input logic exp_tk);
        set_pc(16'h3000);
        issue(instr);
        chk("br_c1_ldben", {15'd0, ld_ben}, 16'd1);
        chk("br_c1_nzp", {13'd0, nzp_mask}, {13'd0, mask});
        ben = b;
        tick();
        chk("br_c2_ldben", {14'd0, ld_ben, done}, 16'd0);
        tick();
        ben = 1'b0;
        chk("br_c3_done", {15'd0, done}, 16'd1);
        chk("br_taken", {15'd0, taken}, {15'd0, exp_tk});
        chk("br_pc", pc, exp_pc);
        tick();
    endtask

    task automatic test_jsr_wrap();
        int w0;
        set_pc(16'hFC01);
        w0 = wr_count;
        issue(16'h4BFF);
        tick();
        tick();
        chk("jsr_done", {14'd0, done, taken}, 16'b11);
        chk("jsr_wrap_pc", pc, 16'h0000);
        chk("jsr_r7", rf[7], 16'hFC01);
        chk("jsr_one_wr", wr_count[15:0], w0[15:0] + 16'd1);
        tick();
        set_pc(16'hFC00);
        issue(16'h4BFF);
        tick();
        tick();
        chk("jsr_fc00_pc", pc, 16'hFFFF);
        chk("jsr_fc00_r7", rf[7], 16'hFC00);
        tick();
    endtask

    task automatic test_back_to_back();
        set_pc(16'h0100);
        issue(16'h1000);
        chk("b2b_first_done", {15'd0, done}, 16'd1);
        tick();
        rf[2] = 16'h0222;
        issue(16'hC080);
        tick();
        chk("b2b_second_done", {14'd0, done, taken}, 16'b11);
        chk("b2b_pc", pc, 16'h0222);
        tick();
    endtask

    task automatic test_reset_mid();
        int w0;
        set_pc(16'h1234);
        w0 = wr_count;
        issue(16'h41C0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("rst_jsr_idle", {14'd0, busy, done}, 16'd0);
        chk("rst_jsr_pc", pc, 16'h0000);
        chk("rst_jsr_wren", {15'd0, rf_wr_en}, 16'd0);
        tick();
        tick();
        chk("rst_jsr_no_wr", wr_count[15:0], w0[15:0]);
        chk("rst_jsr_quiet", {13'd0, busy, done, rf_wr_en}, 16'd0);
        set_pc(16'h3000);
        issue(16'h05FE);
        tick();
        ben   = 1'b1;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        ben   = 1'b0;
        chk("rst_br_idle", {14'd0, busy, done}, 16'd0);
        chk("rst_br_pc", pc, 16'h0000);
        chk("rst_br_flags", {14'd0, taken, ld_ben}, 16'd0);
        tick();
        chk("rst_br_no_done", {14'd0, done, busy}, 16'd0);
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        wr_count = 0;
        Reset    = 1'b1;
        start    = 1'b0;
        ir       = 16'h0000;
        pc_inc   = 1'b0;
        ben      = 1'b0;
        for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
        test_reset();
        test_pc_inc();
        test_jmp();
        test_jsrr();
        test_br(16'h05FE, 1'b1, 3'b010, 16'h2FFE, 1'b1);
        test_br(16'h05FE, 1'b0, 3'b010, 16'h3000, 1'b0);
        test_br(16'h01FE, 1'b0, 3'b000, 16'h3000, 1'b0);
        test_jsr_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
